// File: rtl/fp_div_seq_if.sv
// Operand/result handshake bundle for fp_div_seq.
// Valid/ready: a transfer happens on a rising edge where valid and ready are both high; valid holds its payload until then.
interface fp_div_seq_if #(
  parameter int W = 16
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] flp_a;
  logic [W-1:0] flp_b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] quo;
  logic         ovf;
  logic         unf;
  logic         dz;

  modport master (
    output in_valid, flp_a, flp_b, out_ready,
    input  in_ready, out_valid, quo, ovf, unf, dz
  );

  modport slave (
    input  in_valid, flp_a, flp_b, out_ready,
    output in_ready, out_valid, quo, ovf, unf, dz
  );
endinterface

// File: rtl/fp_div_seq.sv
// Sequential divider for the 16-bit {exp[4:0], mant[10:0]} word.
// Pre-normalizes operands, then restoring division at one quotient bit per cycle.
module fp_div_seq #(
  parameter int EXP_W = 5,
  parameter int MAN_W = 11,
  parameter int BIAS  = 15
) (
  input  logic        clk,
  input  logic        rst,
  fp_div_seq_if.slave io,
  output logic [1:0]  state_o
);
  localparam int W  = EXP_W + MAN_W;
  localparam int XW = EXP_W + 2;

  typedef enum logic [1:0] {IDLE, NORM, DIV, DONE} state_t;

  state_t           state_q;
  logic [MAN_W-1:0] ma_q, mb_q, ma_d, mb_d;
  logic [XW-1:0]    ea_q, eb_q, ea_d, eb_d;
  logic [MAN_W:0]   rem_q, rem_d;
  logic [MAN_W-1:0] rem_sub;
  logic             rem_ge;
  logic [MAN_W-1:0] q_q;
  logic [MAN_W:0]   q_d;
  logic [MAN_W-1:0] m_d;
  logic [XW:0]      e_d;
  logic             pack_ovf, pack_unf;
  logic [3:0]       cnt_q;
  logic [W-1:0]     quo_q;
  logic             ovf_q, unf_q, dz_q, out_valid_q;

  always_comb begin
    ma_d = ma_q[MAN_W-1] ? ma_q : {ma_q[MAN_W-2:0], 1'b0};
    mb_d = mb_q[MAN_W-1] ? mb_q : {mb_q[MAN_W-2:0], 1'b0};
    ea_d = ma_q[MAN_W-1] ? ea_q : ea_q - 1'b1;
    eb_d = mb_q[MAN_W-1] ? eb_q : eb_q - 1'b1;

    // Partial remainder stays below 2*divisor, so after a subtract only the low bits survive.
    rem_ge  = rem_q >= {1'b0, mb_q};
    rem_sub = rem_q[MAN_W-1:0] - mb_q;
    rem_d   = rem_ge ? {rem_sub, 1'b0} : {rem_q[MAN_W-1:0], 1'b0};
    q_d     = {q_q, rem_ge};

    m_d = q_d[MAN_W] ? q_d[MAN_W:1] : q_d[MAN_W-1:0];
    // Exponents are two's complement; one guard bit on top keeps the sum exact.
    e_d = {ea_q[XW-1], ea_q} - {eb_q[XW-1], eb_q}
        + (q_d[MAN_W] ? (XW+1)'(BIAS) : (XW+1)'(BIAS - 1));
    pack_unf = e_d[XW];
    pack_ovf = !e_d[XW] && (|e_d[XW-1:EXP_W]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      ma_q        <= '0;
      mb_q        <= '0;
      ea_q        <= '0;
      eb_q        <= '0;
      rem_q       <= '0;
      q_q         <= '0;
      cnt_q       <= '0;
      quo_q       <= '0;
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
      dz_q        <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (io.in_valid) begin
            ma_q  <= io.flp_a[MAN_W-1:0];
            mb_q  <= io.flp_b[MAN_W-1:0];
            ea_q  <= XW'(io.flp_a[W-1:MAN_W]);
            eb_q  <= XW'(io.flp_b[W-1:MAN_W]);
            rem_q <= {1'b0, io.flp_a[MAN_W-1:0]};
            q_q   <= '0;
            cnt_q <= '0;
            if (io.flp_b == '0) begin
              quo_q       <= '1;
              dz_q        <= 1'b1;
              ovf_q       <= 1'b0;
              unf_q       <= 1'b0;
              out_valid_q <= 1'b1;
              state_q     <= DONE;
            end else if (io.flp_a == '0) begin
              quo_q       <= '0;
              dz_q        <= 1'b0;
              ovf_q       <= 1'b0;
              unf_q       <= 1'b0;
              out_valid_q <= 1'b1;
              state_q     <= DONE;
            end else if (!io.flp_a[MAN_W-1] || !io.flp_b[MAN_W-1]) begin
              state_q <= NORM;
            end else begin
              state_q <= DIV;
            end
          end
        end
        NORM: begin
          ma_q <= ma_d;
          mb_q <= mb_d;
          ea_q <= ea_d;
          eb_q <= eb_d;
          // The count bound only matters for a nonzero word whose mantissa is all zeros.
          if ((ma_d[MAN_W-1] && mb_d[MAN_W-1]) || cnt_q == 4'(MAN_W - 2)) begin
            rem_q   <= {1'b0, ma_d};
            cnt_q   <= '0;
            state_q <= DIV;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DIV: begin
          rem_q <= rem_d;
          q_q   <= q_d[MAN_W-1:0];
          if (cnt_q == 4'(MAN_W)) begin
            cnt_q       <= '0;
            out_valid_q <= 1'b1;
            dz_q        <= 1'b0;
            state_q     <= DONE;
            if (pack_ovf) begin
              quo_q <= '1;
              ovf_q <= 1'b1;
              unf_q <= 1'b0;
            end else if (pack_unf) begin
              quo_q <= '0;
              ovf_q <= 1'b0;
              unf_q <= 1'b1;
            end else begin
              quo_q <= {e_d[EXP_W-1:0], m_d};
              ovf_q <= 1'b0;
              unf_q <= 1'b0;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DONE: begin
          if (io.out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign io.in_ready  = (state_q == IDLE);
  assign io.out_valid = out_valid_q;
  assign io.quo       = quo_q;
  assign io.ovf       = ovf_q;
  assign io.unf       = unf_q;
  assign io.dz        = dz_q;
  assign state_o      = state_q;
endmodule
